bp_be_wb_merge: RTL and testbench

//  Writeback merge stage that sits directly upstream of the dual-write-port integer regfile.
//  - Takes two in-order pipe writebacks (lane 0 = older, lane 1 = younger) plus a

---
 rtl/bp_be_wb_merge_if.sv | 31 +++
 rtl/bp_be_wb_merge.sv | 104 ++++++++++
 tb/tb_bp_be_wb_merge.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bp_be_wb_merge_if.sv
// Writeback merge bus: two in-order pipe lanes, a late-return stream and the two regfile write ports.
// late_v_i/late_ready_o form a valid/ready handshake. A beat transfers on a cycle where both are high, and the producer holds addr/data stable while valid waits.
interface bp_be_wb_merge_if #(
  parameter int data_width_p     = 64,
  parameter int reg_addr_width_p = 5,
  parameter int late_fifo_els_p  = 4
);
  localparam int count_width_lp = $clog2(late_fifo_els_p + 1);

  logic [1:0]                             pipe_v_i;
  logic [1:0][reg_addr_width_p-1:0]       pipe_addr_i;
  logic [1:0][data_width_p-1:0]           pipe_data_i;
  logic                                   late_v_i;
  logic [reg_addr_width_p-1:0]            late_addr_i;
  logic [data_width_p-1:0]                late_data_i;
  logic                                   late_ready_o;
  logic [1:0]                             rd_w_v_o;
  logic [1:0][reg_addr_width_p-1:0]       rd_addr_o;
  logic [1:0][data_width_p-1:0]           rd_data_o;
  logic [count_width_lp-1:0]              late_count_o;

  modport master (
    output pipe_v_i, pipe_addr_i, pipe_data_i, late_v_i, late_addr_i, late_data_i,
    input  late_ready_o, rd_w_v_o, rd_addr_o, rd_data_o, late_count_o
  );

  modport slave (
    input  pipe_v_i, pipe_addr_i, pipe_data_i, late_v_i, late_addr_i, late_data_i,
    output late_ready_o, rd_w_v_o, rd_addr_o, rd_data_o, late_count_o
  );
endinterface

// File: rtl/bp_be_wb_merge.sv
// Writeback merge: filters the two pipe lanes, buffers late returns in a small FIFO and
// registers up to two WAW-free regfile writes per cycle.
module bp_be_wb_merge #(
  parameter int data_width_p     = 64,
  parameter int reg_addr_width_p = 5,
  parameter int late_fifo_els_p  = 4,
  parameter bit zero_x0_p        = 1'b1
) (
  input logic             clk_i,
  input logic             reset_n_i,
  bp_be_wb_merge_if.slave wb
);
  localparam int ptr_width_lp   = $clog2(late_fifo_els_p);
  localparam int count_width_lp = $clog2(late_fifo_els_p + 1);

  logic [reg_addr_width_p-1:0] fifo_addr [late_fifo_els_p];
  logic [data_width_p-1:0]     fifo_data [late_fifo_els_p];
  logic [ptr_width_lp-1:0]     wr_ptr, rd_ptr;
  logic [count_width_lp-1:0]   count;

  logic [1:0]                       out_v;
  logic [1:0][reg_addr_width_p-1:0] out_addr;
  logic [1:0][data_width_p-1:0]     out_data;

  logic [1:0]                  lane_ok, surv;
  logic                        head_v, head_hit, head_port0, head_port1, pop;
  logic                        late_ready, enq_store;
  logic [reg_addr_width_p-1:0] head_addr;
  logic [data_width_p-1:0]     head_data;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      lane_ok[k] = wb.pipe_v_i[k] & ~(zero_x0_p & (wb.pipe_addr_i[k] == '0));
    end
    // Same-cycle WAW between lanes: the younger lane 1 wins.
    surv[1] = lane_ok[1];
    surv[0] = lane_ok[0] & ~(lane_ok[1] & (wb.pipe_addr_i[0] == wb.pipe_addr_i[1]));

    head_v    = (count != '0);
    head_addr = fifo_addr[rd_ptr];
    head_data = fifo_data[rd_ptr];
    // A pipe write to the head's register is newer, so the head write is dead.
    head_hit   = head_v & ((surv[0] & (wb.pipe_addr_i[0] == head_addr)) |
                           (surv[1] & (wb.pipe_addr_i[1] == head_addr)));
    head_port0 = head_v & ~head_hit & ~surv[0];
    head_port1 = head_v & ~head_hit & surv[0] & ~surv[1];
    pop        = head_hit | head_port0 | head_port1;

    late_ready = reset_n_i & (count < count_width_lp'(late_fifo_els_p));
    enq_store  = wb.late_v_i & late_ready & ~(zero_x0_p & (wb.late_addr_i == '0));
  end

  always_ff @(posedge clk_i) begin
    if (enq_store) begin
      fifo_addr[wr_ptr] <= wb.late_addr_i;
      fifo_data[wr_ptr] <= wb.late_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_v    <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      if (enq_store) begin
        wr_ptr <= (wr_ptr == ptr_width_lp'(late_fifo_els_p - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == ptr_width_lp'(late_fifo_els_p - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({enq_store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      out_v <= {surv[1] | head_port1, surv[0] | head_port0};
      if (surv[0]) begin
        out_addr[0] <= wb.pipe_addr_i[0];
        out_data[0] <= wb.pipe_data_i[0];
      end else if (head_port0) begin
        out_addr[0] <= head_addr;
        out_data[0] <= head_data;
      end
      if (surv[1]) begin
        out_addr[1] <= wb.pipe_addr_i[1];
        out_data[1] <= wb.pipe_data_i[1];
      end else if (head_port1) begin
        out_addr[1] <= head_addr;
        out_data[1] <= head_data;
      end
    end
  end

  assign wb.late_ready_o = late_ready;
  assign wb.late_count_o = count;
  assign wb.rd_w_v_o     = out_v;
  assign wb.rd_addr_o    = out_addr;
  assign wb.rd_data_o    = out_data;
endmodule

// File: tb/tb_bp_be_wb_merge.sv
// Bench for bp_be_wb_merge: directed scenarios plus random traffic, all checked against a
// queue-based model of lane filtering, dead-head discard and port allocation.
module tb_bp_be_wb_merge;
  localparam int DW  = 64;
  localparam int AW  = 5;
  localparam int ELS = 4;
  localparam int EW  = AW + DW;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [EW-1:0]      exp_q[$];
  logic [1:0]         exp_v;
  logic [1:0][AW-1:0] exp_addr;
  logic [1:0][DW-1:0] exp_data;

  bp_be_wb_merge_if #(.data_width_p(DW), .reg_addr_width_p(AW), .late_fifo_els_p(ELS)) wb ();

  bp_be_wb_merge #(
    .data_width_p(DW), .reg_addr_width_p(AW), .late_fifo_els_p(ELS), .zero_x0_p(1'b1)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .wb       (wb.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_v    = '0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic check_outputs();
    check("late_ready", DW'(wb.late_ready_o), DW'(exp_q.size() < ELS));
    check("late_count", DW'(wb.late_count_o), DW'(exp_q.size()));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd_w_v[%0d]", k), DW'(wb.rd_w_v_o[k]), DW'(exp_v[k]));
      check($sformatf("rd_addr[%0d]", k), DW'(wb.rd_addr_o[k]), DW'(exp_addr[k]));
      check($sformatf("rd_data[%0d]", k), wb.rd_data_o[k], exp_data[k]);
    end
  endtask

  // One cycle: check what the last edge produced, drive new inputs, advance the model.
  task automatic step(input logic [1:0] pv,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    bit            s0, s1, rdy;
    logic [EW-1:0] h;
    logic [AW-1:0] ha;
    @(negedge clk);
    check_outputs();
    wb.pipe_v_i       = pv;
    wb.pipe_addr_i[0] = a0;
    wb.pipe_data_i[0] = d0;
    wb.pipe_addr_i[1] = a1;
    wb.pipe_data_i[1] = d1;
    wb.late_v_i       = lv;
    wb.late_addr_i    = la;
    wb.late_data_i    = ld;

    rdy = exp_q.size() < ELS;
    s0  = pv[0] && (a0 != 0);
    s1  = pv[1] && (a1 != 0);
    if (s0 && s1 && a0 == a1) s0 = 0;
    exp_v = '0;
    if (s0) begin exp_v[0] = 1'b1; exp_addr[0] = a0; exp_data[0] = d0; end
    if (s1) begin exp_v[1] = 1'b1; exp_addr[1] = a1; exp_data[1] = d1; end
    if (exp_q.size() > 0) begin
      h  = exp_q[0];
      ha = h[EW-1:DW];
      if ((s0 && a0 == ha) || (s1 && a1 == ha)) begin
        void'(exp_q.pop_front());
      end else if (!s0) begin
        exp_v[0] = 1'b1; exp_addr[0] = ha; exp_data[0] = h[DW-1:0];
        void'(exp_q.pop_front());
      end else if (!s1) begin
        exp_v[1] = 1'b1; exp_addr[1] = ha; exp_data[1] = h[DW-1:0];
        void'(exp_q.pop_front());
      end
    end
    if (lv && rdy && la != 0) exp_q.push_back({la, ld});
  endtask

  task automatic idle();
    step(2'b00, '0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    wb.pipe_v_i = '0; wb.pipe_addr_i = '0; wb.pipe_data_i = '0;
    wb.late_v_i = 1'b0; wb.late_addr_i = '0; wb.late_data_i = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_ready", DW'(wb.late_ready_o), DW'(0));
    check("reset_count", DW'(wb.late_count_o), DW'(0));
    rst_n = 1'b1;

    // Two lanes, distinct registers.
    step(2'b11, 5'd3, 64'hA, 5'd4, 64'hB, 1'b0, '0, '0);
    idle();
    // Same-register pair: lane 1 wins.
    step(2'b11, 5'd5, 64'h1, 5'd5, 64'h2, 1'b0, '0, '0);
    idle();
    // Late x7 drains on port 0 once lane 0 is idle.
    step(2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 1'b1, 5'd7, 64'h77);
    step(2'b10, 5'd0, 64'h0, 5'd8, 64'h88, 1'b0, '0, '0);
    idle();
    // Late x9 killed by lane 1 writing x9.
    step(2'b00, '0, '0, '0, '0, 1'b1, 5'd9, 64'h99);
    step(2'b10, 5'd0, 64'h0, 5'd9, 64'h909, 1'b0, '0, '0);
    idle();
    // Fill while both lanes busy, push against full, then drain one at a time.
    for (int i = 0; i < 6; i++)
      step(2'b11, 5'd20, 64'(i), 5'd21, 64'(i + 100), 1'b1, 5'(10 + i), 64'(16'hC0 + i));
    step(2'b01, 5'd20, 64'h5, 5'd0, 64'h0, 1'b1, 5'd16, 64'hD0);
    step(2'b11, 5'd20, 64'h6, 5'd21, 64'h7, 1'b1, 5'd17, 64'hD1);
    repeat (7) idle();
    // Late x0 is accepted but never stored or written.
    step(2'b00, '0, '0, '0, '0, 1'b1, 5'd0, 64'hDEAD);
    idle();

    // Reset mid-operation with two entries queued and writes in flight.
    step(2'b11, 5'd22, 64'h1, 5'd23, 64'h2, 1'b1, 5'd24, 64'h3);
    step(2'b11, 5'd25, 64'h4, 5'd26, 64'h5, 1'b1, 5'd27, 64'h6);
    @(negedge clk);
    check_outputs();
    wb.pipe_v_i = '0;
    wb.late_v_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_w_v", DW'(wb.rd_w_v_o), DW'(0));
    check("rst_rd_addr", DW'(wb.rd_addr_o), DW'(0));
    check("rst_rd_data0", wb.rd_data_o[0], DW'(0));
    check("rst_rd_data1", wb.rd_data_o[1], DW'(0));
    check("rst_count", DW'(wb.late_count_o), DW'(0));
    check("rst_ready", DW'(wb.late_ready_o), DW'(0));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();

    // Random traffic over a small register range to force collisions.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] pv;
      pv = ((i % 200) < 80) ? 2'b11 : 2'($urandom_range(0, 3));
      step(pv, 5'($urandom_range(0, 7)), {$urandom, $urandom},
           5'($urandom_range(0, 7)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
    end
    repeat (8) idle();
    @(negedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
